// File: rtl/calendar_pkg.sv
// ---------------------------------------------------------------------------
// calendar_pkg
// Shared definitions for the calendar datapath (day counter and the
// month/day decoder that consumes its BCD digits).
//   BCD_W           width of one BCD digit
//   DAY_MAX_COMMON  last day of February in a common year (day-of-year 59)
//   DAY_MAX_LEAP    last day of February in a leap year (day-of-year 60)
//   DAY_MIN         first day of the year
//   debounce_state_t  states of the push-button debouncer
//   bcdToBin        converts a two-digit BCD value to binary
// ---------------------------------------------------------------------------
package calendar_pkg;

    localparam int BCD_W          = 4;
    localparam int DAY_MAX_COMMON = 59;
    localparam int DAY_MAX_LEAP   = 60;
    localparam int DAY_MIN        = 1;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } debounce_state_t;

    // Two-digit BCD to binary; the day range never exceeds 69, so 7 bits suffice.
    function automatic logic [6:0] bcdToBin(input logic [BCD_W-1:0] tens,
                                            input logic [BCD_W-1:0] units);
        return ({3'b000, tens} * 7'd10) + {3'b000, units};
    endfunction

endpackage

// File: rtl/day_counter_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Two-flop synchronizer followed by a four-state debounce FSM for an
// active-low push-button. Emits a single-cycle press event per accepted
// press; holding the key never repeats.
// Ports:
//   i_clock      system clock
//   i_reset      synchronous active-high reset
//   i_key_n      raw push-button, active low, asynchronous to i_clock
//   o_press_evt  one-cycle strobe when a press has been stable long enough
// ---------------------------------------------------------------------------
module key_debounce
    import calendar_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_key_n,
    output logic o_press_evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic            r_sync1;
    logic            r_sync2;
    debounce_state_t r_state;
    debounce_state_t w_nextState;
    logic [CNT_W-1:0] r_stableCnt;
    logic            w_cntDone;

    assign w_cntDone = (r_stableCnt == CNT_DONE);

    // Synchronizer resets to the released level so no phantom press follows reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // State register plus stability counter. IDLE and HELD hold the counter
    // at zero, so both wait states always start counting from a clean zero.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_stableCnt <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                PRESS_WAIT: begin
                    if (!r_sync2 && !w_cntDone) begin
                        r_stableCnt <= r_stableCnt + 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    if (r_sync2 && !w_cntDone) begin
                        r_stableCnt <= r_stableCnt + 1'b1;
                    end
                end
                default: r_stableCnt <= '0;
            endcase
        end
    end

    // Next-state logic; reaching the stability count wins over a late glitch.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:         if (!r_sync2) w_nextState = PRESS_WAIT;
            PRESS_WAIT: begin
                if (w_cntDone)    w_nextState = HELD;
                else if (r_sync2) w_nextState = IDLE;
            end
            HELD:         if (r_sync2) w_nextState = RELEASE_WAIT;
            RELEASE_WAIT: begin
                if (w_cntDone)     w_nextState = IDLE;
                else if (!r_sync2) w_nextState = HELD;
            end
            default:      w_nextState = IDLE;
        endcase
    end

    // The press event is the single cycle spent leaving PRESS_WAIT for HELD.
    always_comb begin
        o_press_evt = (r_state == PRESS_WAIT) && w_cntDone;
    end

endmodule

// File: rtl/day_counter.sv
// ---------------------------------------------------------------------------
// day_counter
// BCD day-of-year counter for January-February (01..59, or 01..60 with the
// leap switch). Advances on a debounced key press or on a prescaler tick.
// Optional build macro DAY_COUNTER_DOWN_EN adds a 'dir' input; dir=1 makes
// every advance count down instead of up.
// Ports:
//   clock      system clock
//   reset      synchronous active-high reset
//   key_n      raw advance push-button, active low
//   run        1 enables automatic advance every TICK_DIV cycles
//   SW9        leap-year switch, extends the range to 60
//   dir        (DAY_COUNTER_DOWN_EN only) 1 = count down
//   c10, c1    BCD tens / units of the day count
//   day_pulse  one-cycle strobe when the count changes
//   wrap       one-cycle strobe when the count wraps or is clamped
// ---------------------------------------------------------------------------
module day_counter
    import calendar_pkg::*;
#(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_n,
    input  logic             run,
    input  logic             SW9,
`ifdef DAY_COUNTER_DOWN_EN
    input  logic             dir,
`endif
    output logic [BCD_W-1:0] c10,
    output logic [BCD_W-1:0] c1,
    output logic             day_pulse,
    output logic             wrap
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [BCD_W-1:0] LEAP_TENS    = BCD_W'(DAY_MAX_LEAP / 10);
    localparam logic [BCD_W-1:0] LEAP_UNITS   = BCD_W'(DAY_MAX_LEAP % 10);
    localparam logic [BCD_W-1:0] COMMON_TENS  = BCD_W'(DAY_MAX_COMMON / 10);
    localparam logic [BCD_W-1:0] COMMON_UNITS = BCD_W'(DAY_MAX_COMMON % 10);

    logic [PRE_W-1:0] r_presc;
    logic             w_tick;
    logic             w_pressEvt;
    logic             w_request;
    logic             w_goDown;

    logic [BCD_W-1:0] r_c10;
    logic [BCD_W-1:0] r_c1;
    logic             r_dayPulse;
    logic             r_wrap;
    logic [BCD_W-1:0] w_nextC10;
    logic [BCD_W-1:0] w_nextC1;
    logic             w_nextPulse;
    logic             w_nextWrap;

    logic [6:0]       w_countBin;
    logic [6:0]       w_maxBin;
    logic             w_atMax;
    logic             w_overMax;
    logic             w_atMin;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_keyDebounce (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_key_n    (key_n),
        .o_press_evt(w_pressEvt)
    );

`ifdef DAY_COUNTER_DOWN_EN
    assign w_goDown = dir;
`else
    assign w_goDown = 1'b0;
`endif

    // Prescaler: free-runs only while run=1 and restarts from zero whenever
    // run drops, so the first automatic advance is always a full period away.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick    = run && (r_presc == PRE_LAST);
    assign w_request = w_pressEvt | w_tick;

    assign w_countBin = bcdToBin(r_c10, r_c1);
    assign w_maxBin   = SW9 ? 7'(DAY_MAX_LEAP) : 7'(DAY_MAX_COMMON);
    assign w_atMax    = (w_countBin == w_maxBin);
    assign w_overMax  = (w_countBin > w_maxBin);
    assign w_atMin    = (w_countBin == 7'(DAY_MIN));

    // Next count. An out-of-range value (60 left over after SW9 drops) is
    // pulled back to 01 before any request is honoured.
    always_comb begin
        w_nextC10   = r_c10;
        w_nextC1    = r_c1;
        w_nextPulse = 1'b0;
        w_nextWrap  = 1'b0;
        if (w_overMax) begin
            w_nextC10   = '0;
            w_nextC1    = BCD_W'(DAY_MIN);
            w_nextPulse = 1'b1;
            w_nextWrap  = 1'b1;
        end else if (w_request) begin
            w_nextPulse = 1'b1;
            if (w_goDown) begin
                if (w_atMin) begin
                    w_nextC10  = SW9 ? LEAP_TENS  : COMMON_TENS;
                    w_nextC1   = SW9 ? LEAP_UNITS : COMMON_UNITS;
                    w_nextWrap = 1'b1;
                end else if (r_c1 == '0) begin
                    w_nextC10 = r_c10 - 1'b1;
                    w_nextC1  = BCD_W'(9);
                end else begin
                    w_nextC1 = r_c1 - 1'b1;
                end
            end else begin
                if (w_atMax) begin
                    w_nextC10  = '0;
                    w_nextC1   = BCD_W'(DAY_MIN);
                    w_nextWrap = 1'b1;
                end else if (r_c1 == BCD_W'(9)) begin
                    w_nextC10 = r_c10 + 1'b1;
                    w_nextC1  = '0;
                end else begin
                    w_nextC1 = r_c1 + 1'b1;
                end
            end
        end
    end

    // Count and strobe registers; the downstream decoder samples them on the
    // falling edge, so everything here stays strictly registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_c10      <= '0;
            r_c1       <= BCD_W'(DAY_MIN);
            r_dayPulse <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_c10      <= w_nextC10;
            r_c1       <= w_nextC1;
            r_dayPulse <= w_nextPulse;
            r_wrap     <= w_nextWrap;
        end
    end

    assign c10       = r_c10;
    assign c1        = r_c1;
    assign day_pulse = r_dayPulse;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_day_counter.sv
// ---------------------------------------------------------------------------
// tb_day_counter
// Self-checking bench for day_counter with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// A reference model tracks the day as a plain integer; the expected digits
// are day/10 and day%10. Define DAY_COUNTER_DOWN_EN to exercise 'dir'.
// ---------------------------------------------------------------------------
module tb_day_counter;

    localparam int TICK_DIV  = 4;
    localparam int DEB       = 3;
    localparam int PRESS_LAT = 2 + DEB + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_n;
    logic       run;
    logic       SW9;
`ifdef DAY_COUNTER_DOWN_EN
    logic       dir;
`endif
    logic [3:0] c10;
    logic [3:0] c1;
    logic       day_pulse;
    logic       wrap;

    int   compared   = 0;
    int   mismatched = 0;
    int   edgeNum    = 0;
    int   day        = 1;
    int   runLen     = 0;
    logic expPulse   = 1'b0;
    logic expWrap    = 1'b0;
    int   pressDue[$];
    logic prevKey    = 1'b1;
    bit   autoPress  = 1'b1;
    logic dirVal     = 1'b0;

    day_counter #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .key_n    (key_n),
        .run      (run),
        .SW9      (SW9),
`ifdef DAY_COUNTER_DOWN_EN
        .dir      (dir),
`endif
        .c10      (c10),
        .c1       (c1),
        .day_pulse(day_pulse),
        .wrap     (wrap)
    );

    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected, edgeNum);
        end
    endtask

    // Reference model for one clock edge, stated in days rather than digits.
    task automatic modelUpdate(input logic rstVal, input logic runVal,
                               input logic swVal, input logic dVal);
        bit req;
        bit tick;
        int maxDay;
        if (rstVal) begin
            day      = 1;
            runLen   = 0;
            expPulse = 1'b0;
            expWrap  = 1'b0;
            pressDue.delete();
            return;
        end
        tick   = runVal && ((runLen % TICK_DIV) == TICK_DIV - 1);
        runLen = runVal ? runLen + 1 : 0;
        req    = tick;
        if (pressDue.size() > 0 && pressDue[0] == edgeNum) begin
            req = 1'b1;
            void'(pressDue.pop_front());
        end
        maxDay   = swVal ? 60 : 59;
        expPulse = 1'b0;
        expWrap  = 1'b0;
        if (day > maxDay) begin
            day      = 1;
            expPulse = 1'b1;
            expWrap  = 1'b1;
        end else if (req) begin
            expPulse = 1'b1;
            if (dVal) begin
                if (day == 1) begin
                    day     = maxDay;
                    expWrap = 1'b1;
                end else begin
                    day = day - 1;
                end
            end else begin
                if (day == maxDay) begin
                    day     = 1;
                    expWrap = 1'b1;
                end else begin
                    day = day + 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check after it.
    task automatic applyStimulus(input logic keyVal, input logic runVal,
                                 input logic swVal, input logic rstVal);
        key_n = keyVal;
        run   = runVal;
        SW9   = swVal;
        reset = rstVal;
`ifdef DAY_COUNTER_DOWN_EN
        dir   = dirVal;
`endif
        if (autoPress && !rstVal && !keyVal && prevKey) begin
            pressDue.push_back(edgeNum + 1 + PRESS_LAT);
        end
        prevKey = keyVal;
        @(posedge clock);
        edgeNum++;
        modelUpdate(rstVal, runVal, swVal, dirVal);
        #1;
        checkOutput("c10", c10, day / 10);
        checkOutput("c1", c1, day % 10);
        checkOutput("day_pulse", day_pulse, int'(expPulse));
        checkOutput("wrap", wrap, int'(expWrap));
    endtask

    task automatic runUntil(input int target, input logic runVal,
                            input logic swVal, input int maxCycles);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b1, runVal, swVal, 1'b0);
            n++;
        end while (day != target && n < maxCycles);
        if (day != target) checkOutput("timeout_runUntil", day, target);
    endtask

    initial begin
        int  pulses;
        int  keyTimer;
        bit  keyLow;
        logic runR;
        logic swR;

        // Reset and idle
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_c10", c10, 0);
        checkOutput("reset_c1", c1, 1);
        checkOutput("reset_pulse", day_pulse, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_c1", c1, 1);

        // Automatic advance, common year
        runUntil(9, 1'b1, 1'b0, 100);
        runUntil(10, 1'b1, 1'b0, 10);
        checkOutput("carry_c10", c10, 1);
        checkOutput("carry_c1", c1, 0);
        runUntil(59, 1'b1, 1'b0, 400);
        runUntil(1, 1'b1, 1'b0, 10);
        checkOutput("wrap59_flag", wrap, 1);

        // Leap year and clamp
        runUntil(59, 1'b1, 1'b1, 400);
        runUntil(60, 1'b1, 1'b1, 10);
        checkOutput("leap_c10", c10, 6);
        checkOutput("leap_c1", c1, 0);
        runUntil(1, 1'b1, 1'b1, 10);
        checkOutput("wrap60_flag", wrap, 1);
        runUntil(60, 1'b1, 1'b1, 400);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("clamp_c1", c1, 1);
        checkOutput("clamp_wrap", wrap, 1);
        checkOutput("clamp_pulse", day_pulse, 1);

        // Bouncy key press and release, run=0: exactly one increment
        autoPress = 1'b0;
        pulses = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        pulses += int'(day_pulse);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        pulses += int'(day_pulse);
        pressDue.push_back(edgeNum + 1 + PRESS_LAT);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            pulses += int'(day_pulse);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        pulses += int'(day_pulse);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        pulses += int'(day_pulse);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            pulses += int'(day_pulse);
        end
        checkOutput("bounce_c1", c1, 2);
        checkOutput("bounce_pulses", pulses, 1);
        autoPress = 1'b1;
        prevKey   = 1'b1;

        // Press event lands on the same edge as a tick at 05
        runUntil(4, 1'b1, 1'b0, 20);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("coincide_c1", c1, 6);
        checkOutput("coincide_pulse", day_pulse, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("after_coincide_c1", c1, 7);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of counting
        runUntil(37, 1'b1, 1'b0, 400);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("midreset_c10", c10, 0);
        checkOutput("midreset_c1", c1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

`ifdef DAY_COUNTER_DOWN_EN
        // Counting down
        dirVal = 1'b1;
        runUntil(60, 1'b1, 1'b1, 10);
        checkOutput("down_wrap_flag", wrap, 1);
        checkOutput("down_wrap_c10", c10, 6);
        runUntil(59, 1'b1, 1'b1, 10);
        checkOutput("down_59_c1", c1, 9);
        runUntil(10, 1'b1, 1'b1, 400);
        runUntil(9, 1'b1, 1'b1, 10);
        checkOutput("down_borrow_c10", c10, 0);
        checkOutput("down_borrow_c1", c1, 9);
        dirVal = 1'b0;
`endif

        // Randomized mix of clean presses, run toggles and leap switching
        keyLow   = 1'b0;
        keyTimer = 20;
        runR     = 1'b0;
        swR      = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if (keyTimer == 0) begin
                if (keyLow) begin
                    keyLow   = 1'b0;
                    keyTimer = int'($urandom_range(8, 20));
                end else begin
                    keyLow   = 1'b1;
                    keyTimer = int'($urandom_range(5, 12));
                end
            end
            keyTimer--;
            if ($urandom_range(0, 19) == 0) runR = ~runR;
            if ($urandom_range(0, 59) == 0) swR = ~swR;
`ifdef DAY_COUNTER_DOWN_EN
            if ($urandom_range(0, 99) == 0) dirVal = ~dirVal;
`endif
            applyStimulus(~keyLow, runR, swR, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
